display_digit_converter: RTL and testbench

//   Converts the 8-bit output-register value into four display digit codes
//   for the seven-segment multiplexer. Sits directly upstream of the

---
 rtl/display_digit_converter.sv | 109 ++++++++++
 tb/tb_display_digit_converter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_digit_converter.sv
// display_digit_converter: 8-bit value to four display digit codes via sequential double-dabble
module display_digit_converter #(
  parameter bit AUTO_RELOAD   = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value_i,
  input  logic        neg_i,
  input  logic        hex_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] digits_o,
  output logic [3:0]  blank_o,
  output logic [3:0]  minus_o
);
  typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;
  localparam logic [3:0] BLANK_RST = BLANK_LEADING ? 4'b1110 : 4'b1000;
  state_t      state_q, state_d;
  logic [9:0]  last_q, last_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d, minus_q, minus_d;
  logic        valid_q, valid_d;
  logic [11:0] bcd_adj;
  logic        start, neg_cap, hz, tz, m3, m2, m1;
  // next-state, double-dabble step and display formatting; last_q holds the captured {value,neg,hex}
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    minus_d  = minus_q;
    valid_d  = 1'b0;
    start    = load_i || (AUTO_RELOAD && ({value_i, neg_i, hex_i} != last_q));
    neg_cap  = last_q[1] && last_q[9] && !last_q[0];
    for (int i = 0; i < 3; i++)
      bcd_adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    hz = bcd_q[11:8] == 4'd0;
    tz = bcd_q[7:4] == 4'd0;
    m3 = sign_q && (!BLANK_LEADING || !hz);
    m2 = sign_q && BLANK_LEADING && hz && !tz;
    m1 = sign_q && BLANK_LEADING && hz && tz;
    case (state_q)
      IDLE: if (start) begin
        last_d  = {value_i, neg_i, hex_i};
        state_d = PREP;
      end
      PREP: begin
        bin_d   = neg_cap ? 8'd0 - last_q[9:2] : last_q[9:2];
        sign_d  = neg_cap;
        bcd_d   = 12'd0;
        cnt_d   = 3'd0;
        state_d = last_q[0] ? DONE : SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        state_d        = (cnt_q == 3'd7) ? DONE : SHIFT;
      end
      default: begin
        digits_d = last_q[0] ? {8'h00, last_q[9:2]} : {4'h0, bcd_q};
        blank_d  = last_q[0] ? 4'b1100 : {!m3, BLANK_LEADING && hz && !m2, BLANK_LEADING && hz && tz && !m1, 1'b0};
        minus_d  = last_q[0] ? 4'b0000 : {m3, m2, m1, 1'b0};
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
  // state and datapath registers; reset also aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 10'd0;
      bin_q    <= 8'd0;
      bcd_q    <= 12'd0;
      sign_q   <= 1'b0;
      cnt_q    <= 3'd0;
      digits_q <= 16'h0000;
      blank_q  <= BLANK_RST;
      minus_q  <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      minus_q  <= minus_d;
      valid_q  <= valid_d;
    end
  end
  assign busy_o   = state_q != IDLE;
  assign valid_o  = valid_q;
  assign digits_o = digits_q;
  assign blank_o  = blank_q;
  assign minus_o  = minus_q;
endmodule

// File: tb/tb_display_digit_converter.sv
// tb_display_digit_converter: randomized and directed checks of display_digit_converter against an arithmetic model
module tb_display_digit_converter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  value_i = 8'h00;
  logic        neg_i = 1'b0, hex_i = 1'b0, load_i = 1'b0;
  logic        busy_o, valid_o;
  logic [15:0] digits_o;
  logic [3:0]  blank_o, minus_o;
  int nvec = 0, nerr = 0;

  display_digit_converter #(.AUTO_RELOAD(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .neg_i(neg_i), .hex_i(hex_i), .load_i(load_i),
    .busy_o(busy_o), .valid_o(valid_o), .digits_o(digits_o), .blank_o(blank_o), .minus_o(minus_o)
  );

  always #5 clk = ~clk;

  // What the display should read: digits shown, leading zeros blanked, '-' just left of the leading digit
  function automatic void model(input logic [7:0] v, input logic n, input logic h,
                                output logic [15:0] d, output logic [3:0] b, output logic [3:0] m);
    int mag, nd, mp;
    bit s;
    if (h) begin
      d = {8'h00, v};
      b = 4'b1100;
      m = 4'b0000;
      return;
    end
    s   = n && (v > 8'd127);
    mag = s ? 256 - int'(v) : int'(v);
    d   = {4'h0, 4'(mag / 100), 4'(mag / 10 % 10), 4'(mag % 10)};
    nd  = (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
    mp  = s ? nd : -1;
    for (int i = 0; i < 4; i++) b[i] = (i >= nd) && (i != mp);
    m = s ? 4'(1 << mp) : 4'b0000;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy_o); end
    nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid_o); end
    nvec++; if (digits_o !== 16'h0000) begin nerr++; $display("FAIL reset_digits got %h want 0000", digits_o); end
    nvec++; if (blank_o !== 4'b1110) begin nerr++; $display("FAIL reset_blank got %b want 1110", blank_o); end
    nvec++; if (minus_o !== 4'b0000) begin nerr++; $display("FAIL reset_minus got %b want 0000", minus_o); end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL idle_no_autostart got busy %b want 0", busy_o); end
  endtask

  task automatic do_conv(input logic [7:0] v, input logic n, input logic h, input string tag);
    logic [15:0] ed, pd;
    logic [3:0]  eb, em, pb, pm;
    int k, lat;
    bit held;
    model(v, n, h, ed, eb, em);
    lat  = h ? 2 : 10;
    pd   = digits_o; pb = blank_o; pm = minus_o;
    held = 1'b1;
    @(negedge clk);
    value_i = v; neg_i = n; hex_i = h; load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1 k++;
      if (valid_o) break;
      if ({digits_o, blank_o, minus_o} !== {pd, pb, pm} || busy_o !== 1'b1) held = 1'b0;
    end
    nvec++; if (k !== lat) begin nerr++; $display("FAIL %s_latency v=%h got %0d want %0d", tag, v, k, lat); end
    nvec++; if (!held) begin nerr++; $display("FAIL %s_hold v=%h outputs changed or busy low mid-conversion", tag, v); end
    nvec++; if (digits_o !== ed) begin nerr++; $display("FAIL %s_digits v=%h n=%b h=%b got %h want %h", tag, v, n, h, digits_o, ed); end
    nvec++; if (blank_o !== eb) begin nerr++; $display("FAIL %s_blank v=%h n=%b h=%b got %b want %b", tag, v, n, h, blank_o, eb); end
    nvec++; if (minus_o !== em) begin nerr++; $display("FAIL %s_minus v=%h n=%b h=%b got %b want %b", tag, v, n, h, minus_o, em); end
    @(posedge clk);
    #1;
    nvec++; if ({valid_o, busy_o} !== 2'b00) begin nerr++; $display("FAIL %s_pulse got valid/busy %b%b want 00", tag, valid_o, busy_o); end
  endtask

  task automatic test_directed();
    do_conv(8'd123, 1'b0, 1'b0, "dec123");
    do_conv(8'hA8, 1'b1, 1'b0, "neg88");
    do_conv(8'h80, 1'b1, 1'b0, "neg128");
    do_conv(8'h80, 1'b0, 1'b0, "uns128");
    do_conv(8'hFF, 1'b0, 1'b1, "hexFF");
    do_conv(8'hAB, 1'b1, 1'b1, "hexAB");
    do_conv(8'h00, 1'b0, 1'b1, "hex00");
    do_conv(8'h00, 1'b0, 1'b0, "dec0");
    do_conv(8'hFF, 1'b1, 1'b0, "neg1");
    do_conv(8'hF6, 1'b1, 1'b0, "neg10");
    do_conv(8'd9, 1'b1, 1'b0, "pos9");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      do_conv(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), "rand");
  endtask

  task automatic test_back_to_back();
    int nv, first;
    bit busy_gap;
    @(negedge clk);
    value_i = 8'd77; neg_i = 1'b0; hex_i = 1'b0; load_i = 1'b1;
    @(negedge clk) load_i = 1'b0;
    repeat (3) @(negedge clk);
    load_i = 1'b1;
    @(negedge clk) load_i = 1'b0;
    nv = 0; first = 0; busy_gap = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin nv++; if (first == 0) first = k; end
      else if (first != 0 && busy_o) busy_gap = 1'b0;
    end
    nvec++; if (nv !== 1) begin nerr++; $display("FAIL b2b_valid_count got %0d want 1", nv); end
    nvec++; if (!busy_gap) begin nerr++; $display("FAIL b2b_restart busy rose after completion"); end
    nvec++; if (digits_o !== 16'h0077) begin nerr++; $display("FAIL b2b_digits got %h want 0077", digits_o); end
  endtask

  task automatic test_auto_reload();
    logic [15:0] ed;
    logic [3:0]  eb, em;
    int k;
    @(negedge clk);
    value_i = 8'd45; neg_i = 1'b0; hex_i = 1'b0; load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) begin value_i = 8'hC8; neg_i = 1'b1; end
    k = 3;
    while (k < 20) begin @(posedge clk); #1 k++; if (valid_o) break; end
    model(8'd45, 1'b0, 1'b0, ed, eb, em);
    nvec++; if (k !== 10 || digits_o !== ed) begin nerr++; $display("FAIL auto_first got k=%0d d=%h want k=10 d=%h", k, digits_o, ed); end
    nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL auto_gap got busy %b want 0", busy_o); end
    k = 0;
    while (k < 20) begin @(posedge clk); #1 k++; if (valid_o) break; end
    model(8'hC8, 1'b1, 1'b0, ed, eb, em);
    nvec++; if (k !== 11) begin nerr++; $display("FAIL auto_second_latency got %0d want 11", k); end
    nvec++; if ({digits_o, blank_o, minus_o} !== {ed, eb, em}) begin
      nerr++; $display("FAIL auto_second got %h/%b/%b want %h/%b/%b", digits_o, blank_o, minus_o, ed, eb, em);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    int k;
    bit early;
    @(negedge clk);
    value_i = 8'd200; neg_i = 1'b0; hex_i = 1'b0; load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    nvec++; if ({busy_o, valid_o} !== 2'b00) begin nerr++; $display("FAIL rst_mid_ctrl got busy/valid %b%b want 00", busy_o, valid_o); end
    nvec++; if ({digits_o, blank_o, minus_o} !== {16'h0000, 4'b1110, 4'b0000}) begin
      nerr++; $display("FAIL rst_mid_outputs got %h/%b/%b want 0000/1110/0000", digits_o, blank_o, minus_o);
    end
    @(negedge clk) rst = 1'b0;
    k = 0; early = 1'b0;
    while (k < 20) begin @(posedge clk); #1 k++; if (valid_o) break; if (digits_o !== 16'h0000) early = 1'b1; end
    nvec++; if (k !== 11 || early) begin nerr++; $display("FAIL rst_restart_latency got %0d early=%b want 11", k, early); end
    nvec++; if ({digits_o, blank_o, minus_o} !== {16'h0200, 4'b1000, 4'b0000}) begin
      nerr++; $display("FAIL rst_restart_out got %h/%b/%b want 0200/1000/0000", digits_o, blank_o, minus_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_auto_reload();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
